// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states,
// stream framing lengths and the default instruction memory size.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int unsigned HDR_LEN           = 2;
    localparam int unsigned CHK_LEN           = 1;
    localparam int unsigned MEM_BYTES_DEFAULT = 1024;

    // A word count is usable when it is non-zero and fits the memory.
    function automatic logic len_ok(input logic [15:0] n, input int unsigned mem_bytes);
        return (n != '0) && (32'(n) <= mem_bytes / 4);
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input, instruction-memory write port and core status
// signals of the loader, grouped as one bundle.
interface inst_loader_if;

    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_wr_en, cpu_hold, done, err
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_wr_en, cpu_hold, done, err
    );

endinterface

// File: rtl/inst_loader.sv
// Boot loader: assembles little-endian words from a length-prefixed,
// XOR-checksummed byte stream and writes them into instruction memory.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    inst_loader_if.master bus
);

    state_t      state;
    state_t      state_next;

    logic [15:0] len_q;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  xor_q;
    logic [23:0] word_buf;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        rx_ready;
    logic        rx_fire;
    logic [15:0] len_hdr;

    assign rx_ready = (state == ST_LEN0) || (state == ST_LEN1) ||
                      (state == ST_DATA) || (state == ST_CHK);
    assign rx_fire  = rx_ready && bus.rx_valid;
    assign len_hdr  = {bus.rx_data, len_q[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) state_next = ST_LEN0;
            end
            ST_LEN0: begin
                if (rx_fire) state_next = ST_LEN1;
            end
            ST_LEN1: begin
                if (rx_fire) state_next = len_ok(len_hdr, MEM_BYTES) ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                if (rx_fire && (byte_cnt == 2'd3)) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                state_next = (word_idx == len_q - 16'd1) ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                if (rx_fire) state_next = (bus.rx_data == xor_q) ? ST_DONE : ST_ERR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address and data are captured with the 4th byte so they are already
    // stable for the whole single-cycle WRITE strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            xor_q    <= '0;
            word_buf <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (bus.start) begin
                        word_idx <= '0;
                        byte_cnt <= '0;
                        xor_q    <= '0;
                    end
                end
                ST_LEN0: begin
                    if (rx_fire) len_q[7:0] <= bus.rx_data;
                end
                ST_LEN1: begin
                    if (rx_fire) len_q[15:8] <= bus.rx_data;
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        xor_q    <= xor_q ^ bus.rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            default: begin
                                wdata_q <= {bus.rx_data, word_buf};
                                addr_q  <= 32'({word_idx, 2'b00});
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    word_idx <= word_idx + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr_en = (state == ST_WRITE);
    assign bus.cpu_hold  = (state != ST_DONE);
    assign bus.done      = (state == ST_DONE);
    assign bus.err       = (state == ST_ERR);

endmodule
